// File: rtl/bus_xfer_ctrl.sv
// Register-to-register transfer sequencer over a shared wired-AND bus.
// Drives registered active-low assert/load strobes and tracks sticky error flags.
module bus_xfer_ctrl #(
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      NREGS  = 4,
  parameter int unsigned      IDXW   = 2,
  parameter logic [WIDTH-1:0] PULLUP = {WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [IDXW-1:0]        cmd_src,
  input  logic [IDXW-1:0]        cmd_dst,
  input  logic [NREGS*WIDTH-1:0] src_data,
  input  logic [NREGS-1:0]       src_en,
  output logic [NREGS-1:0]       assert_n,
  output logic [NREGS-1:0]       load_n,
  output logic [WIDTH-1:0]       bus_value,
  output logic [WIDTH-1:0]       last_data,
  output logic                   done,
  output logic                   err_contention,
  output logic                   err_index
);

  typedef enum logic [1:0] {StIdle, StAssert, StLoad, StDone} state_e;

  state_e           state_q, state_d;
  logic [NREGS-1:0] assert_n_q, assert_n_d;
  logic [NREGS-1:0] load_n_q, load_n_d;
  logic [IDXW-1:0]  dst_q, dst_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             cont_q, cont_d;
  logic             idx_q, idx_d;

  logic [WIDTH-1:0] bus_and;
  logic             cmd_bad;
  logic             multi_drv;

  assign cmd_bad   = (32'(cmd_src) >= NREGS) || (32'(cmd_dst) >= NREGS);
  // Clearing the lowest set bit leaves something only when two or more drivers are on.
  assign multi_drv = |(src_en & (src_en - NREGS'(1)));

  always_comb begin
    bus_and = '1;
    for (int i = 0; i < NREGS; i++) begin
      if (src_en[i]) bus_and = bus_and & src_data[i*WIDTH +: WIDTH];
    end
    bus_value = (src_en == '0) ? PULLUP : bus_and;
  end

  always_comb begin
    state_d    = state_q;
    assert_n_d = '1;
    load_n_d   = '1;
    dst_d      = dst_q;
    last_d     = last_q;
    cont_d     = cont_q;
    idx_d      = idx_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            idx_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StAssert;
            dst_d   = cmd_dst;
            for (int i = 0; i < NREGS; i++) assert_n_d[i] = (IDXW'(i) != cmd_src);
          end
        end
      end
      StAssert: begin
        state_d    = StLoad;
        assert_n_d = assert_n_q;
        for (int i = 0; i < NREGS; i++) load_n_d[i] = (IDXW'(i) != dst_q);
        if (multi_drv) cont_d = 1'b1;
      end
      StLoad: begin
        state_d = StDone;
        last_d  = bus_value;
        if (multi_drv) cont_d = 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      assert_n_q <= '1;
      load_n_q   <= '1;
      dst_q      <= '0;
      last_q     <= PULLUP;
      cont_q     <= 1'b0;
      idx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      assert_n_q <= assert_n_d;
      load_n_q   <= load_n_d;
      dst_q      <= dst_d;
      last_q     <= last_d;
      cont_q     <= cont_d;
      idx_q      <= idx_d;
    end
  end

  assign cmd_ready      = (state_q == StIdle);
  assign done           = (state_q == StDone);
  assign assert_n       = assert_n_q;
  assign load_n         = load_n_q;
  assign last_data      = last_q;
  assign err_contention = cont_q;
  assign err_index      = idx_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: four modelled bus registers on the main instance, plus a
// three-register instance sharing the command inputs for out-of-range index cases.
module tb_bus_xfer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_src, cmd_dst;
  logic [31:0] src_data;
  logic [3:0]  src_en, assert_n, load_n;
  logic [7:0]  bus_value, last_data;
  logic        cmd_ready, done, err_contention, err_index;

  logic        cmd_ready3, done3, err_c3, err_i3;
  logic [2:0]  assert_n3, load_n3;
  logic [7:0]  bus_value3, last_data3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .src_data(src_data), .src_en(src_en),
    .assert_n(assert_n), .load_n(load_n), .bus_value(bus_value), .last_data(last_data),
    .done(done), .err_contention(err_contention), .err_index(err_index)
  );

  bus_xfer_ctrl #(.WIDTH(8), .NREGS(3), .IDXW(2)) u_dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .src_data(src_data[23:0]), .src_en(src_en[2:0]),
    .assert_n(assert_n3), .load_n(load_n3), .bus_value(bus_value3), .last_data(last_data3),
    .done(done3), .err_contention(err_c3), .err_index(err_i3)
  );

  // Register environment: a register drives when its assert strobe is low and its
  // drive bit is set; extra forces enables to create contention.
  logic [7:0] regs [4];
  logic       pre_we;
  logic [1:0] pre_idx;
  logic [7:0] pre_val;
  logic [3:0] drive, extra;

  always @(posedge clk) begin
    if (pre_we) regs[pre_idx] <= pre_val;
    for (int i = 0; i < 4; i++) if (!load_n[i]) regs[i] <= bus_value;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) src_data[i*8 +: 8] = regs[i];
    src_en = (~assert_n & drive) | extra;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [1:0] idx, input logic [7:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_xfer(input logic [1:0] s, input logic [1:0] d, input logic [7:0] exp_v);
    logic [3:0] sa, dl;
    sa = ~(4'b0001 << s);
    dl = ~(4'b0001 << d);
    @(negedge clk);
    cmd_src = s; cmd_dst = d; cmd_valid = 1'b1;
    check("ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("assert_n_in_assert", assert_n, sa);
    check("load_n_in_assert", load_n, 4'hF);
    check("done_in_assert", done, 0);
    @(negedge clk);
    check("assert_n_in_load", assert_n, sa);
    check("load_n_in_load", load_n, dl);
    check("bus_in_load", bus_value, exp_v);
    @(negedge clk);
    check("assert_n_in_done", assert_n, 4'hF);
    check("load_n_in_done", load_n, 4'hF);
    check("done_pulse", done, 1);
    check("last_data", last_data, exp_v);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("ready_after", cmd_ready, 1);
  endtask

  typedef struct {
    logic [1:0] src, dst;
    logic [3:0] drive, extra;
    logic [7:0] r0, r1;
    logic [7:0] exp_last;
    logic       exp_cont;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] exp_mem [4];
  logic       exp_cont;
  int         accepts, dones, acc_cyc [3], overlap;

  initial begin
    vecs[0] = '{src: 2'd1, dst: 2'd3, drive: 4'hF, extra: 4'h0, r0: 8'h00, r1: 8'h5A,
                exp_last: 8'h5A, exp_cont: 1'b0};
    vecs[1] = '{src: 2'd0, dst: 2'd2, drive: 4'h0, extra: 4'h0, r0: 8'h00, r1: 8'h5A,
                exp_last: 8'hFF, exp_cont: 1'b0};
    vecs[2] = '{src: 2'd0, dst: 2'd2, drive: 4'hF, extra: 4'h2, r0: 8'hF0, r1: 8'h3C,
                exp_last: 8'h30, exp_cont: 1'b1};
    vecs[3] = '{src: 2'd3, dst: 2'd0, drive: 4'hF, extra: 4'h0, r0: 8'hF0, r1: 8'h3C,
                exp_last: 8'h5A, exp_cont: 1'b1};
    vecs[4] = '{src: 2'd2, dst: 2'd2, drive: 4'hF, extra: 4'h0, r0: 8'h66, r1: 8'h99,
                exp_last: 8'h30, exp_cont: 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0; drive = 4'hF; extra = 4'h0;
    for (int i = 0; i < 4; i++) preload(2'(i), 8'h10 + 8'(i));
    check("rst_assert_n", assert_n, 4'hF);
    check("rst_load_n", load_n, 4'hF);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_last", last_data, 8'hFF);
    check("rst_flags", {err_contention, err_index}, 0);

    // Out-of-range source on the three-register instance, first edge after reset.
    @(posedge clk); #3 reset = 1'b0;
    @(negedge clk);
    cmd_src = 2'd3; cmd_dst = 2'd1; cmd_valid = 1'b1;
    check("bad_ready", cmd_ready3, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bad_done", done3, 1);
    check("bad_assert_n", assert_n3, 3'b111);
    check("bad_load_n", load_n3, 3'b111);
    check("bad_err_index", err_i3, 1);
    check("bad_last", last_data3, 8'hFF);
    @(negedge clk);
    check("bad_done_cleared", done3, 0);
    check("bad_ready_after", cmd_ready3, 1);
    check("bad_strobes_after", {assert_n3, load_n3}, 6'h3F);
    check("main_no_index_err", err_index, 0);
    @(negedge clk); @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      preload(2'd0, vecs[v].r0);
      preload(2'd1, vecs[v].r1);
      drive = vecs[v].drive; extra = vecs[v].extra;
      run_xfer(vecs[v].src, vecs[v].dst, vecs[v].exp_last);
      check($sformatf("vec%0d_reg_dst", v), regs[vecs[v].dst], vecs[v].exp_last);
      check($sformatf("vec%0d_contention", v), err_contention, vecs[v].exp_cont);
    end
    extra = 4'h0; drive = 4'hF;
    check("bad_index_sticky", err_i3, 1);

    // Reset arriving during LOAD aborts the transfer.
    @(negedge clk);
    cmd_src = 2'd1; cmd_dst = 2'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_load", load_n, 4'b1110);
    #2 reset = 1'b1;
    #1;
    check("abort_assert_n", assert_n, 4'hF);
    check("abort_load_n", load_n, 4'hF);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    check("abort_last", last_data, 8'hFF);
    check("abort_flags", {err_contention, err_index}, 0);
    @(negedge clk);
    check("abort_no_done", done, 0);
    check("abort_reg_kept", regs[0], 8'h66);
    @(posedge clk); #3 reset = 1'b0;
    run_xfer(2'd1, 2'd0, 8'h99);

    // Back-to-back commands with cmd_valid held high.
    accepts = 0; dones = 0; overlap = 0;
    cmd_src = 2'd0; cmd_dst = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (accepts == 3) cmd_valid = 1'b0;
      if (done) dones++;
      if ($countones(~assert_n) > 1 || $countones(~load_n) > 1) overlap++;
      if (cmd_ready && (assert_n != 4'hF || load_n != 4'hF)) overlap++;
      if (cmd_valid && cmd_ready) begin
        acc_cyc[accepts] = cyc;
        accepts++;
      end
    end
    check("b2b_accepts", accepts, 3);
    check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 4);
    check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 4);
    check("b2b_dones", dones, 3);
    check("b2b_overlap", overlap, 0);

    // Randomized transfers against a value-level model of the register file.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("flags_cleared_by_reset", {err_contention, err_index}, 0);
    for (int i = 0; i < 4; i++) begin
      exp_mem[i] = 8'($urandom);
      preload(2'(i), exp_mem[i]);
    end
    exp_cont = 1'b0;
    for (int t = 0; t < 30; t++) begin
      logic [1:0] s, d;
      logic [3:0] en;
      logic [7:0] val;
      s = 2'($urandom_range(0, 3));
      d = 2'($urandom_range(0, 3));
      drive = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      extra = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      en = extra;
      if (drive[s]) en[s] = 1'b1;
      val = 8'hFF;
      for (int k = 0; k < 4; k++) if (en[k]) val = val & exp_mem[k];
      if ($countones(en) >= 2) exp_cont = 1'b1;
      exp_mem[d] = val;
      run_xfer(s, d, val);
      check("rnd_reg_dst", regs[d], exp_mem[d]);
      check("rnd_contention", err_contention, exp_cont);
      check("rnd_index", err_index, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
